vend_controller: RTL and testbench
==================================

// Module: vend_controller
// PURPOSE
//  Sequencing controller for the tea/coffee vending datapath. Accepts coin
//  pulses and accumulates credit, then arbitrates drink selection against price.
//  Drives timed dispense strobes and pays out change one coin per cycle.
//  Sits between the coin acceptor/keypad front end and the dispense solenoids.
// PARAMETERS
//  TEA_PRICE     7     price of tea, Rs
//  COFFEE_PRICE  9     price of coffee, Rs
//  MAX_CREDIT    20    highest credit held; any coin that would exceed it is rejected
//  CREDIT_W      5     credit register width; must hold MAX_CREDIT+5
//  DISPENSE_CYC  4     cycles a dispense strobe stays high
//  TIMEOUT_CYC   1000  idle cycles in COLLECT before auto-refund
// PORTS
//  clk              in   1         single clock, rising edge
//  rst              in   1         synchronous reset, active-high
//  coin_valid       in   1         one-cycle coin pulse
//  coin_type        in   2         00=Rs1, 01=Rs2, 10=Rs5, 11=invalid
//  sel_valid        in   1         one-cycle drink request
//  sel_drink        in   1         0=tea, 1=coffee
//  cancel           in   1         one-cycle refund request
//  dispense_tea     out  1         tea solenoid strobe
//  dispense_coffee  out  1         coffee solenoid strobe
//  change_rs2       out  1         pay one Rs2 coin (pulse)
//  change_rs1       out  1         pay one Rs1 coin (pulse)
//  coin_reject      out  1         coin returned unaccepted (pulse)
//  sel_nack         out  1         selection refused: insufficient credit (pulse)
//  credit           out  CREDIT_W  current credit, Rs
//  busy             out  1         high in DISPENSE or CHANGE
// BEHAVIOUR
//  - All outputs registered. On rst: state=IDLE, credit=0, all outputs 0.
//  - rst mid-operation: credit is forfeited; no change is paid out.
//  - States: IDLE, COLLECT, DISPENSE, CHANGE.
//  - IDLE: a valid coin sets credit=value and moves to COLLECT.
//  - IDLE: sel_valid -> sel_nack. cancel -> no effect.
//  - COLLECT priority, per cycle: cancel > sel_valid > coin_valid.
//  - COLLECT: if another event wins the cycle, a coin_valid in that cycle is rejected.
//  - COLLECT coin: if credit+value <= MAX_CREDIT, credit += value.
//    Otherwise, or if type 11, coin_reject pulses and credit is unchanged.
//  - COLLECT sel, credit >= price: latch drink, credit -= price, go to DISPENSE.
//  - COLLECT sel, credit < price: sel_nack pulses; stay in COLLECT; credit unchanged.
//  - COLLECT cancel: go to CHANGE.
//  - Timeout counter clears on entry to COLLECT and on each accepted coin or nacked sel.
//    At TIMEOUT_CYC-1 it forces CHANGE.
//  - Timing: sel accepted at edge N -> strobe high in cycles N+1..N+DISPENSE_CYC.
//  - DISPENSE exit: to CHANGE if credit > 0, else to IDLE.
//  - In DISPENSE and CHANGE every coin is rejected; sel_nack is given for any sel; cancel is ignored.
//  - CHANGE, one coin per cycle: credit >= 2 -> change_rs2 pulse, credit -= 2.
//    credit == 1 -> change_rs1 pulse, credit -= 1.
//  - CHANGE exits to IDLE in the cycle after credit reaches 0.
//  - Never assert both change outputs in one cycle, nor both dispense strobes.
//  - Entering CHANGE with credit 0 (cancel at zero credit is not possible) is illegal.
//    Assert against it.
//  - Width: compute credit+value at CREDIT_W+1 bits before comparing.
// STRUCTURE
//  - vend_pkg: state enum; coin_type codes; coin_value() function (1/2/5/0);
//    default price constants.
//  - Sub-module vend_change_payout: holds credit down-counter and rs2/rs1 pulse logic.
//    Its interface is load/start in, done out.
//  - The FSM, timeout counter and dispense counter stay in vend_controller.
// TESTING
//  1. Rs5,Rs2 then sel tea -> dispense_tea high 4 cycles, no change, IDLE, credit=0.
//  2. Rs5,Rs5 then sel coffee -> dispense_coffee 4 cycles, then one change_rs1, IDLE.
//  3. Rs5 then sel coffee -> sel_nack, credit=5.
//     Then cancel -> change_rs2 x2, change_rs1 x1, IDLE.
//  4. Credit 18; insert Rs5 -> coin_reject, credit=18.
//     coin_type=11 -> coin_reject, credit=18.
//  5. Rs2 then 1000 idle cycles -> one change_rs2, IDLE.
//     Same-cycle coin+cancel -> coin_reject, refund of prior credit only.
//  6. rst asserted during DISPENSE -> next cycle all outputs 0, credit=0, no change pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types, coin codes and default pricing for the vending controller.
package vend_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} vend_state_t;

    localparam logic [1:0] COIN_RS1 = 2'b00;
    localparam logic [1:0] COIN_RS2 = 2'b01;
    localparam logic [1:0] COIN_RS5 = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam int DEF_TEA_PRICE    = 7;
    localparam int DEF_COFFEE_PRICE = 9;
    localparam int DEF_MAX_CREDIT   = 20;
    localparam int DEF_CREDIT_W     = 5;
    localparam int DEF_DISPENSE_CYC = 4;
    localparam int DEF_TIMEOUT_CYC  = 1000;

    function automatic logic [2:0] coin_value(input logic [1:0] t);
        case (t)
            COIN_RS1: return 3'd1;
            COIN_RS2: return 3'd2;
            COIN_RS5: return 3'd5;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_payout.sv
// Credit register: loaded by the controller while collecting, counted down
// one coin per cycle (Rs2 first, then Rs1) while start is held.
module vend_change_payout #(
    parameter int CREDIT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    input  logic                start,
    output logic [CREDIT_W-1:0] credit,
    output logic                change_rs2,
    output logic                change_rs1,
    output logic                done
);

    // done marks the cycle after the last coin went out
    assign done = start && (credit == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            credit     <= '0;
            change_rs2 <= 1'b0;
            change_rs1 <= 1'b0;
        end else begin
            change_rs2 <= 1'b0;
            change_rs1 <= 1'b0;
            if (load) begin
                credit <= load_val;
            end else if (start) begin
                if (credit >= CREDIT_W'(2)) begin
                    credit     <= credit - CREDIT_W'(2);
                    change_rs2 <= 1'b1;
                end else if (credit == CREDIT_W'(1)) begin
                    credit     <= credit - CREDIT_W'(1);
                    change_rs1 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Tea/coffee vending sequencer: coin accumulation, selection vs price,
// timed dispense strobes and change payout.
module vend_controller
    import vend_pkg::*;
#(
    parameter int TEA_PRICE    = DEF_TEA_PRICE,
    parameter int COFFEE_PRICE = DEF_COFFEE_PRICE,
    parameter int MAX_CREDIT   = DEF_MAX_CREDIT,
    parameter int CREDIT_W     = DEF_CREDIT_W,
    parameter int DISPENSE_CYC = DEF_DISPENSE_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                sel_valid,
    input  logic                sel_drink,
    input  logic                cancel,
    output logic                dispense_tea,
    output logic                dispense_coffee,
    output logic                change_rs2,
    output logic                change_rs1,
    output logic                coin_reject,
    output logic                sel_nack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int SW = CREDIT_W + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int DW = $clog2(DISPENSE_CYC + 1);

    vend_state_t         state;
    logic [TW-1:0]       tcnt;
    logic [DW-1:0]       dcnt;
    logic [2:0]          cval;
    logic [SW-1:0]       sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] price;
    logic                load;
    logic [CREDIT_W-1:0] load_val;
    logic                pay_done;

    // Credit arithmetic carries one extra bit so an overflowing coin is seen
    always_comb begin
        cval     = coin_value(coin_type);
        sum      = {1'b0, credit} + SW'(cval);
        coin_ok  = coin_valid && (cval != 3'd0) && (sum <= SW'(MAX_CREDIT));
        price    = sel_drink ? CREDIT_W'(COFFEE_PRICE) : CREDIT_W'(TEA_PRICE);
        load     = 1'b0;
        load_val = credit;
        case (state)
            IDLE: begin
                if (coin_valid && (cval != 3'd0)) begin
                    load     = 1'b1;
                    load_val = CREDIT_W'(cval);
                end
            end
            COLLECT: begin
                if (cancel) begin
                    load = 1'b0;
                end else if (sel_valid) begin
                    if (credit >= price) begin
                        load     = 1'b1;
                        load_val = credit - price;
                    end
                end else if (coin_ok) begin
                    load     = 1'b1;
                    load_val = sum[CREDIT_W-1:0];
                end
            end
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            tcnt            <= '0;
            dcnt            <= '0;
            dispense_tea    <= 1'b0;
            dispense_coffee <= 1'b0;
            coin_reject     <= 1'b0;
            sel_nack        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            sel_nack    <= 1'b0;
            case (state)
                IDLE: begin
                    sel_nack    <= sel_valid;
                    coin_reject <= coin_valid && (cval == 3'd0);
                    if (coin_valid && (cval != 3'd0)) begin
                        state <= COLLECT;
                        tcnt  <= '0;
                    end
                end
                COLLECT: begin
                    if (cancel) begin
                        state       <= CHANGE;
                        busy        <= 1'b1;
                        coin_reject <= coin_valid;
                    end else if (sel_valid) begin
                        coin_reject <= coin_valid;
                        if (credit >= price) begin
                            state           <= DISPENSE;
                            busy            <= 1'b1;
                            dcnt            <= DW'(DISPENSE_CYC - 1);
                            dispense_tea    <= !sel_drink;
                            dispense_coffee <= sel_drink;
                        end else begin
                            sel_nack <= 1'b1;
                            tcnt     <= '0;
                        end
                    end else if (coin_ok) begin
                        tcnt <= '0;
                    end else begin
                        // rejected coins do not restart the inactivity timer
                        coin_reject <= coin_valid;
                        if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                            state <= CHANGE;
                            busy  <= 1'b1;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                DISPENSE: begin
                    coin_reject <= coin_valid;
                    sel_nack    <= sel_valid;
                    if (dcnt == '0) begin
                        dispense_tea    <= 1'b0;
                        dispense_coffee <= 1'b0;
                        if (credit != '0) begin
                            state <= CHANGE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        dcnt <= dcnt - DW'(1);
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_valid;
                    sel_nack    <= sel_valid;
                    if (pay_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    vend_change_payout #(.CREDIT_W(CREDIT_W)) u_payout (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val),
        .start      (state == CHANGE),
        .credit     (credit),
        .change_rs2 (change_rs2),
        .change_rs1 (change_rs1),
        .done       (pay_done)
    );

    a_change_nonzero: assert property (@(posedge clk) disable iff (rst)
        (state == CHANGE && $past(state) != CHANGE) |-> (credit != '0));
    a_one_change: assert property (@(posedge clk) disable iff (rst)
        !(change_rs2 && change_rs1));
    a_one_strobe: assert property (@(posedge clk) disable iff (rst)
        !(dispense_tea && dispense_coffee));

endmodule

// File: tb/tb_vend_controller.sv
// Randomized and directed bench for vend_controller against a queue-based reference model.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst, coin_valid, sel_valid, sel_drink, cancel;
    logic [1:0] coin_type;
    logic       dispense_tea, dispense_coffee, change_rs2, change_rs1;
    logic       coin_reject, sel_nack, busy;
    logic [4:0] credit;

    int vectors = 0;
    int miscompares = 0;

    vend_controller dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel_drink(sel_drink), .cancel(cancel),
        .dispense_tea(dispense_tea), .dispense_coffee(dispense_coffee),
        .change_rs2(change_rs2), .change_rs1(change_rs1),
        .coin_reject(coin_reject), .sel_nack(sel_nack),
        .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: credit as a number, refund as a queue of coins to pay
    // (0 = the empty exit cycle), dispense as cycles remaining.
    int m_credit = 0, m_disp_left = 0, m_idle = 0;
    bit m_collect = 0;
    int m_q[$];
    bit e_tea = 0, e_cof = 0, e_rs2 = 0, e_rs1 = 0, e_rej = 0, e_nack = 0, e_busy = 0;
    int cnt [6] = '{default: 0};  // tea, coffee, rs2, rs1, reject, nack

    task automatic build_refund();
        int c;
        c = m_credit;
        m_q.delete();
        while (c >= 2) begin m_q.push_back(2); c -= 2; end
        if (c == 1) m_q.push_back(1);
        m_q.push_back(0);
        m_collect = 0;
    endtask

    task automatic model_step();
        int val, price, p;
        e_rej = 0; e_nack = 0; e_rs2 = 0; e_rs1 = 0;
        if (rst) begin
            m_credit = 0; m_disp_left = 0; m_collect = 0; m_idle = 0; m_q.delete();
            e_tea = 0; e_cof = 0; e_busy = 0;
            return;
        end
        val = (coin_type == 2'b00) ? 1 : (coin_type == 2'b01) ? 2 : (coin_type == 2'b10) ? 5 : 0;
        if (m_disp_left > 0) begin
            e_rej = coin_valid; e_nack = sel_valid;
            m_disp_left--;
            if (m_disp_left == 0) begin
                e_tea = 0; e_cof = 0;
                if (m_credit > 0) build_refund();
                e_busy = (m_q.size() > 0);
            end
        end else if (m_q.size() > 0) begin
            e_rej = coin_valid; e_nack = sel_valid;
            p = m_q.pop_front();
            e_rs2 = (p == 2); e_rs1 = (p == 1);
            m_credit -= p;
            e_busy = (m_q.size() > 0);
        end else if (m_collect) begin
            if (cancel) begin
                e_rej = coin_valid; build_refund(); e_busy = 1;
            end else if (sel_valid) begin
                e_rej = coin_valid;
                price = sel_drink ? 9 : 7;
                if (m_credit >= price) begin
                    m_credit -= price; m_disp_left = 4; m_collect = 0;
                    e_tea = !sel_drink; e_cof = sel_drink; e_busy = 1;
                end else begin
                    e_nack = 1; m_idle = 0;
                end
            end else if (coin_valid && val != 0 && m_credit + val <= 20) begin
                m_credit += val; m_idle = 0;
            end else begin
                e_rej = coin_valid;
                if (m_idle == 999) begin build_refund(); e_busy = 1; end
                else m_idle++;
            end
        end else begin
            e_nack = sel_valid;
            if (coin_valid) begin
                if (val != 0) begin m_credit = val; m_collect = 1; m_idle = 0; end
                else e_rej = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("credit", credit, m_credit);
        chk("dispense_tea", dispense_tea, e_tea);
        chk("dispense_coffee", dispense_coffee, e_cof);
        chk("change_rs2", change_rs2, e_rs2);
        chk("change_rs1", change_rs1, e_rs1);
        chk("coin_reject", coin_reject, e_rej);
        chk("sel_nack", sel_nack, e_nack);
        chk("busy", busy, e_busy);
        cnt[0] += int'(dispense_tea);  cnt[1] += int'(dispense_coffee);
        cnt[2] += int'(change_rs2);    cnt[3] += int'(change_rs1);
        cnt[4] += int'(coin_reject);   cnt[5] += int'(sel_nack);
    end

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1; coin_type = t;
        @(negedge clk);
        coin_valid = 1'b0;
    endtask

    task automatic sel(input logic d);
        sel_valid = 1'b1; sel_drink = d;
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic cxl();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base [6];

    initial begin
        rst = 1'b1; coin_valid = 1'b0; coin_type = 2'b00;
        sel_valid = 1'b0; sel_drink = 1'b0; cancel = 1'b0;
        idle(2);
        rst = 1'b0;
        chk("reset_credit", credit, 0);
        chk("reset_busy", busy, 0);

        // Rs5 + Rs2, tea: exact price
        base = cnt;
        coin(2'b10); coin(2'b01); sel(1'b0); idle(8);
        chk("t1_tea_cycles", cnt[0] - base[0], 4);
        chk("t1_change", (cnt[2] + cnt[3]) - (base[2] + base[3]), 0);
        chk("t1_credit", credit, 0);

        // Rs5 + Rs5, coffee: Rs1 change
        base = cnt;
        coin(2'b10); coin(2'b10); sel(1'b1); idle(10);
        chk("t2_coffee_cycles", cnt[1] - base[1], 4);
        chk("t2_rs1", cnt[3] - base[3], 1);
        chk("t2_rs2", cnt[2] - base[2], 0);
        chk("t2_busy", busy, 0);

        // short credit then cancel
        base = cnt;
        coin(2'b10); sel(1'b1);
        chk("t3_nack", cnt[5] - base[5], 1);
        chk("t3_credit", credit, 5);
        cxl(); idle(6);
        chk("t3_rs2", cnt[2] - base[2], 2);
        chk("t3_rs1", cnt[3] - base[3], 1);
        chk("t3_credit_end", credit, 0);

        // overflow and invalid coins at credit 18
        coin(2'b10); coin(2'b10); coin(2'b10); coin(2'b01); coin(2'b00);
        chk("t4_credit18", credit, 18);
        base = cnt;
        coin(2'b10);
        chk("t4_over_reject", cnt[4] - base[4], 1);
        chk("t4_over_credit", credit, 18);
        coin(2'b11);
        chk("t4_bad_reject", cnt[4] - base[4], 2);
        chk("t4_bad_credit", credit, 18);
        cxl(); idle(12);

        // inactivity timeout, then coin+cancel in one cycle
        base = cnt;
        coin(2'b01); idle(1005);
        chk("t5_timeout_rs2", cnt[2] - base[2], 1);
        chk("t5_timeout_credit", credit, 0);
        base = cnt;
        coin(2'b10);
        coin_valid = 1'b1; coin_type = 2'b01; cancel = 1'b1;
        @(negedge clk);
        coin_valid = 1'b0; cancel = 1'b0;
        idle(6);
        chk("t5_cc_reject", cnt[4] - base[4], 1);
        chk("t5_cc_rs2", cnt[2] - base[2], 2);
        chk("t5_cc_rs1", cnt[3] - base[3], 1);

        // reset mid-dispense forfeits credit
        coin(2'b10); coin(2'b10); sel(1'b0); idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t6_tea", dispense_tea, 0);
        chk("t6_busy", busy, 0);
        chk("t6_credit", credit, 0);
        base = cnt;
        idle(8);
        chk("t6_no_change", (cnt[2] + cnt[3]) - (base[2] + base[3]), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            coin_valid = ($urandom_range(0, 99) < 30);
            coin_type  = 2'($urandom_range(0, 3));
            sel_valid  = ($urandom_range(0, 99) < 10);
            sel_drink  = 1'($urandom_range(0, 1));
            cancel     = ($urandom_range(0, 99) < 4);
            rst        = ($urandom_range(0, 999) < 3);
            @(negedge clk);
        end
        coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; rst = 1'b0;
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
